// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM pipeline stage: default widths, FSM encodings
// and the timeout counter width helper.
package mem_stage_pkg;

   localparam int DW_DEF      = 32;
   localparam int RW_DEF      = 5;
   localparam int TIMEOUT_DEF = 255;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_BUSY = 1'b1;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register. On load it captures the stage results; on bubble
// it clears every field so write-back sees a harmless no-op.
module mem_wb_reg #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          bubble,
   input  logic          d_MemtoReg,
   input  logic          d_RegWrite,
   input  logic [DW-1:0] d_mem_data,
   input  logic [DW-1:0] d_alu_out,
   input  logic [RW-1:0] d_rfile_wn,
   output logic          q_MemtoReg,
   output logic          q_RegWrite,
   output logic [DW-1:0] q_mem_data,
   output logic [DW-1:0] q_alu_out,
   output logic [RW-1:0] q_rfile_wn
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_MemtoReg <= 1'b0;
         q_RegWrite <= 1'b0;
         q_mem_data <= '0;
         q_alu_out  <= '0;
         q_rfile_wn <= '0;
      end else if (load) begin
         q_MemtoReg <= d_MemtoReg;
         q_RegWrite <= d_RegWrite;
         q_mem_data <= d_mem_data;
         q_alu_out  <= d_alu_out;
         q_rfile_wn <= d_rfile_wn;
      end else if (bubble) begin
         q_MemtoReg <= 1'b0;
         q_RegWrite <= 1'b0;
         q_mem_data <= '0;
         q_alu_out  <= '0;
         q_rfile_wn <= '0;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: branch resolution, data-memory req/ready FSM with upstream stall,
// and the MEM/WB register. Define MEM_TIMEOUT_EN to abort accesses that wait too long.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DW             = DW_DEF,
   parameter int RW             = RW_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          MemtoReg,
   input  logic          RegWrite,
   input  logic          MemRead,
   input  logic          MemWrite,
   input  logic          Branch,
   input  logic          Beq,
   input  logic          zero,
   input  logic          bgtz,
   input  logic [DW-1:0] b_tgt,
   input  logic [DW-1:0] alu_out,
   input  logic [DW-1:0] RD2,
   input  logic [RW-1:0] rfile_wn,
   output logic          pc_src,
   output logic [DW-1:0] pc_tgt,
   output logic          stall,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [DW-1:0] dmem_addr,
   output logic [DW-1:0] dmem_wdata,
   input  logic [DW-1:0] dmem_rdata,
   input  logic          dmem_ready,
   output logic          mem_err,
   output logic          wb_MemtoReg,
   output logic          wb_RegWrite,
   output logic [DW-1:0] wb_mem_data,
   output logic [DW-1:0] wb_alu_out,
   output logic [RW-1:0] wb_rfile_wn
);

   logic          state;
   logic [DW-1:0] lat_addr;
   logic [DW-1:0] lat_wdata;
   logic          lat_we;
   logic          mem_op;
   logic          misaligned;
   logic          start;
   logic          done;
   logic          timeout_hit;
   logic          wb_load;
   logic [DW-1:0] wb_data_in;

   assign pc_src     = (Branch & ((Beq & zero) | (~Beq & ~zero))) | bgtz;
   assign pc_tgt     = b_tgt;

   // MemRead and MemWrite together fall through as a write via lat_we.
   assign mem_op     = MemRead | MemWrite;
   assign misaligned = |alu_out[1:0];
   assign start      = (state == ST_IDLE) & mem_op & ~misaligned;
   assign done       = (state == ST_BUSY) & dmem_ready;

`ifdef MEM_TIMEOUT_EN
   localparam int CW = cnt_width(TIMEOUT_CYCLES);
   logic [CW-1:0] wait_cnt;

   // Fires on the last allowed BUSY cycle; a same-cycle ready takes priority.
   assign timeout_hit = (state == ST_BUSY) & ~dmem_ready &
                        (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         wait_cnt <= '0;
      else if (start)
         wait_cnt <= '0;
      else if (state == ST_BUSY)
         wait_cnt <= wait_cnt + 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      stall = 1'b0;
      if (rst) begin
         if (state == ST_IDLE)
            stall = mem_op & ~misaligned;
         else
            stall = ~dmem_ready & ~timeout_hit;
      end
   end

   assign dmem_req   = (state == ST_BUSY);
   assign dmem_we    = lat_we;
   assign dmem_addr  = lat_addr;
   assign dmem_wdata = lat_wdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_we    <= 1'b0;
         mem_err   <= 1'b0;
      end else begin
         mem_err <= ((state == ST_IDLE) & mem_op & misaligned) | timeout_hit;
         if (start) begin
            state     <= ST_BUSY;
            lat_addr  <= alu_out;
            lat_wdata <= RD2;
            lat_we    <= MemWrite;
         end else if (done | timeout_hit) begin
            state <= ST_IDLE;
         end
      end
   end

   // Anything that is not a completed instruction becomes a bubble.
   assign wb_load    = ((state == ST_IDLE) & ~mem_op) | done;
   assign wb_data_in = (done & ~lat_we) ? dmem_rdata : '0;

   mem_wb_reg #(.DW(DW), .RW(RW)) u_mem_wb (
      .clk        (clk),
      .rst        (rst),
      .load       (wb_load),
      .bubble     (~wb_load),
      .d_MemtoReg (MemtoReg),
      .d_RegWrite (RegWrite),
      .d_mem_data (wb_data_in),
      .d_alu_out  (alu_out),
      .d_rfile_wn (rfile_wn),
      .q_MemtoReg (wb_MemtoReg),
      .q_RegWrite (wb_RegWrite),
      .q_mem_data (wb_mem_data),
      .q_alu_out  (wb_alu_out),
      .q_rfile_wn (wb_rfile_wn)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for ALU/branch traffic plus
// hand-written load, store, misaligned, reset and (MEM_TIMEOUT_EN) timeout sequences.
module tb_mem_stage;

   localparam int DW = 32;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          MemtoReg, RegWrite, MemRead, MemWrite;
   logic          Branch, Beq, zero, bgtz;
   logic [DW-1:0] b_tgt, alu_out, RD2, dmem_rdata;
   logic [RW-1:0] rfile_wn;
   logic          dmem_ready;
   logic          pc_src, stall, dmem_req, dmem_we, mem_err;
   logic [DW-1:0] pc_tgt, dmem_addr, dmem_wdata;
   logic          wb_MemtoReg, wb_RegWrite;
   logic [DW-1:0] wb_mem_data, wb_alu_out;
   logic [RW-1:0] wb_rfile_wn;

   int checks = 0;
   int errors = 0;

   mem_stage #(.DW(DW), .RW(RW), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .Branch(Branch), .Beq(Beq), .zero(zero), .bgtz(bgtz),
      .b_tgt(b_tgt), .alu_out(alu_out), .RD2(RD2), .rfile_wn(rfile_wn),
      .pc_src(pc_src), .pc_tgt(pc_tgt), .stall(stall),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .mem_err(mem_err),
      .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite),
      .wb_mem_data(wb_mem_data), .wb_alu_out(wb_alu_out), .wb_rfile_wn(wb_rfile_wn)
   );

   // clock / reset
   always #5 clk = ~clk;

   typedef struct {
      logic          memtoreg;
      logic          regwrite;
      logic          branch;
      logic          beq;
      logic          zero;
      logic          bgtz;
      logic [DW-1:0] b_tgt;
      logic [DW-1:0] alu_out;
      logic [RW-1:0] wn;
      logic          exp_pc_src;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_nop();
      MemtoReg = 0; RegWrite = 0; MemRead = 0; MemWrite = 0;
      Branch = 0; Beq = 0; zero = 0; bgtz = 0;
      b_tgt = '0; alu_out = '0; RD2 = '0; rfile_wn = '0;
      dmem_ready = 0; dmem_rdata = '0;
   endtask

   task automatic chk_bubble(input string name);
      chk({name, ".wb_RegWrite"}, DW'(wb_RegWrite), 0);
      chk({name, ".wb_MemtoReg"}, DW'(wb_MemtoReg), 0);
      chk({name, ".wb_alu_out"},  wb_alu_out, 0);
      chk({name, ".wb_mem_data"}, wb_mem_data, 0);
      chk({name, ".wb_rfile_wn"}, DW'(wb_rfile_wn), 0);
   endtask

   initial begin
      int stall_cycles;

      vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_1234, 5'd5,  1'b0};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_0000, 5'd0,  1'b1};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0000_0004, 5'd0,  1'b0};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_0008, 5'd0,  1'b1};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'h0000_0000, 5'd0,  1'b0};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 32'h0000_0001, 5'd0,  1'b1};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_5000, 32'h0000_0000, 5'd0,  1'b0};
      vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 5'd31, 1'b0};

      drive_nop();
      rst = 0;
      #12;
      chk("rst.dmem_req", DW'(dmem_req), 0);
      chk("rst.stall",    DW'(stall), 0);
      chk("rst.mem_err",  DW'(mem_err), 0);
      chk_bubble("rst");
      @(negedge clk);
      rst = 1;
      tick();

      // ALU and branch vectors
      for (int i = 0; i < 8; i++) begin
         MemtoReg = vecs[i].memtoreg; RegWrite = vecs[i].regwrite;
         Branch = vecs[i].branch; Beq = vecs[i].beq; zero = vecs[i].zero; bgtz = vecs[i].bgtz;
         b_tgt = vecs[i].b_tgt; alu_out = vecs[i].alu_out; rfile_wn = vecs[i].wn;
         #1;
         chk($sformatf("v%0d.pc_src", i), DW'(pc_src), DW'(vecs[i].exp_pc_src));
         chk($sformatf("v%0d.pc_tgt", i), pc_tgt, vecs[i].b_tgt);
         chk($sformatf("v%0d.stall", i), DW'(stall), 0);
         tick();
         chk($sformatf("v%0d.wb_alu_out", i), wb_alu_out, vecs[i].alu_out);
         chk($sformatf("v%0d.wb_rfile_wn", i), DW'(wb_rfile_wn), DW'(vecs[i].wn));
         chk($sformatf("v%0d.wb_RegWrite", i), DW'(wb_RegWrite), DW'(vecs[i].regwrite));
         chk($sformatf("v%0d.wb_MemtoReg", i), DW'(wb_MemtoReg), DW'(vecs[i].memtoreg));
         chk($sformatf("v%0d.wb_mem_data", i), wb_mem_data, 0);
         chk($sformatf("v%0d.dmem_req", i), DW'(dmem_req), 0);
      end
      drive_nop();
      tick();

      // load at 0x40, ready on the third BUSY cycle
      MemRead = 1; MemtoReg = 1; RegWrite = 1; alu_out = 32'h40; rfile_wn = 5'd7;
      stall_cycles = 0;
      #1;
      chk("ld.idle_req", DW'(dmem_req), 0);
      if (stall) stall_cycles++;
      tick();
      chk_bubble("ld.entry");
      for (int c = 0; c < 3; c++) begin
         if (c == 2) begin
            dmem_ready = 1; dmem_rdata = 32'hCAFE_F00D;
         end
         #1;
         chk($sformatf("ld.req%0d", c), DW'(dmem_req), 1);
         chk($sformatf("ld.addr%0d", c), dmem_addr, 32'h40);
         chk($sformatf("ld.we%0d", c), DW'(dmem_we), 0);
         if (stall) stall_cycles++;
         tick();
      end
      chk("ld.stall_cycles", DW'(stall_cycles), 3);
      chk("ld.wb_mem_data", wb_mem_data, 32'hCAFE_F00D);
      chk("ld.wb_MemtoReg", DW'(wb_MemtoReg), 1);
      chk("ld.wb_RegWrite", DW'(wb_RegWrite), 1);
      chk("ld.wb_rfile_wn", DW'(wb_rfile_wn), 7);
      chk("ld.wb_alu_out", wb_alu_out, 32'h40);
      chk("ld.req_done", DW'(dmem_req), 0);
      drive_nop();
      tick();

      // store at 0x80; RD2 changes during BUSY but wdata must stay latched
      MemWrite = 1; alu_out = 32'h80; RD2 = 32'hDEAD_BEEF;
      #1;
      chk("st.stall", DW'(stall), 1);
      tick();
      RD2 = 32'h1111_2222;
      for (int c = 0; c < 2; c++) begin
         if (c == 1) begin
            dmem_ready = 1; dmem_rdata = 32'h5555_AAAA;
         end
         #1;
         chk($sformatf("st.we%0d", c), DW'(dmem_we), 1);
         chk($sformatf("st.wdata%0d", c), dmem_wdata, 32'hDEAD_BEEF);
         chk($sformatf("st.addr%0d", c), dmem_addr, 32'h80);
         tick();
      end
      chk("st.wb_RegWrite", DW'(wb_RegWrite), 0);
      chk("st.wb_mem_data", wb_mem_data, 0);
      drive_nop();
      tick();

      // misaligned load at 0x41
      MemRead = 1; MemtoReg = 1; RegWrite = 1; alu_out = 32'h41; rfile_wn = 5'd9;
      #1;
      chk("mis.stall", DW'(stall), 0);
      chk("mis.req", DW'(dmem_req), 0);
      tick();
      chk("mis.err", DW'(mem_err), 1);
      chk("mis.req_after", DW'(dmem_req), 0);
      chk_bubble("mis");
      drive_nop();
      tick();
      chk("mis.err_pulse", DW'(mem_err), 0);

      // reset while BUSY
      MemRead = 1; alu_out = 32'h100; RegWrite = 1; rfile_wn = 5'd3;
      tick();
      #1;
      chk("rb.req_busy", DW'(dmem_req), 1);
      rst = 0;
      #1;
      chk("rb.req", DW'(dmem_req), 0);
      chk("rb.stall", DW'(stall), 0);
      chk("rb.addr", dmem_addr, 0);
      chk_bubble("rb");
      drive_nop();
      @(negedge clk);
      rst = 1;
      tick();
      chk("rb.idle_req", DW'(dmem_req), 0);

`ifdef MEM_TIMEOUT_EN
      // no ready: abort after four BUSY cycles
      MemRead = 1; MemtoReg = 1; RegWrite = 1; alu_out = 32'h200; rfile_wn = 5'd4;
      tick();
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("to.req%0d", c), DW'(dmem_req), 1);
         chk($sformatf("to.stall%0d", c), DW'(stall), (c == 3) ? 0 : 1);
         chk($sformatf("to.err%0d", c), DW'(mem_err), 0);
         tick();
      end
      chk("to.err", DW'(mem_err), 1);
      chk("to.req_off", DW'(dmem_req), 0);
      chk_bubble("to");
      drive_nop();
      tick();
      chk("to.err_pulse", DW'(mem_err), 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
